// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per cycle through a single
// registered carry, with a start/busy/done handshake and held results.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken on a rising edge only when busy = 0 (IDLE or DONE);
  // done is a one-cycle pulse and s/carry_out/overflow hold until the next done.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] r_nxt;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));
  assign dsum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  // Carry into the top bit of the digit, recovered from the sum bit and its operands.
  assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign r_nxt   = (r_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state != RUN) begin
      if (accept) begin
        a_q <= x;
        b_q <= sub ? ~y : y;
        c_q <= carry_in ^ sub;
        cnt <= '0;
      end
    end else begin
      a_q <= a_q >> DIGIT;
      b_q <= b_q >> DIGIT;
      r_q <= r_nxt;
      c_q <= dsum[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        s         <= r_nxt;
        carry_out <= dsum[DIGIT];
        overflow  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

endmodule
